shift_unit_param: RTL and testbench
===================================

Name: shift_unit_param

Overview:
- Parametrised successor to the 4-bit doubler/shifter: a WIDTH-bit data register with eight opcode-selected operations.
- Multi-bit shifts and rotates execute serially, one bit per cycle, behind a valid/ready handshake.
- A saturating counter tracks completed operations.
- Sits in the datapath as a reusable shift/scale stage driven by a control sequencer.

Parameters:
- WIDTH, 8, data register width (>=2).
- CNT_WIDTH, 8, operation counter width.
- DOUBLE_SAT, 0: 0 = DOUBLE wraps (shift left, drop MSB); 1 = DOUBLE saturates to all-ones when MSB is set.
- SH_W, $clog2(WIDTH), width of the shift-amount field (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- op_valid  input  1  request strobe.
- op_ready  output  1  high when IDLE and able to accept a request.
- control  input  3  opcode, sampled on accept.
- data_in  input  WIDTH  LOAD operand, sampled on accept.
- shamt  input  SH_W  shift/rotate amount, sampled on accept.
- cnt_clr  input  1  synchronous clear of op_count and count_sat.
- data_out  output  WIDTH  data register.
- done  output  1  one-cycle pulse on operation completion.
- op_count  output  CNT_WIDTH  completed-operation count.
- count_sat  output  1  sticky; set when op_count reaches its all-ones value.

Behaviour:
- Reset (async, rst_n=0): data_out=0, op_ready=1, done=0, op_count=0, count_sat=0, FSM=IDLE. Reset mid-shift abandons the operation; no done pulse.
- Accept: a request is accepted when op_valid && op_ready at a rising edge. op_valid while busy is ignored; there is no queueing.
- Opcodes:
  - 000 NOP: data unchanged; done pulses; not counted.
  - 001 CLEAR: data=0.
  - 010 LOAD: data=data_in.
  - 011 SHL: logical left, zero fill.
  - 100 SHR: logical right, zero fill.
  - 101 ASR: arithmetic right, MSB replicated.
  - 110 ROL: rotate left.
  - 111 DOUBLE: x2 per DOUBLE_SAT.
- Single-cycle ops (NOP, CLEAR, LOAD, DOUBLE):
  - The result is registered on the accept edge.
  - done=1 in the following cycle.
  - op_ready stays 1, so back-to-back accepts every cycle are allowed.
- Serial ops (SHL, SHR, ASR, ROL) with shamt=k:
  - k=0: behaves as single-cycle; data unchanged; counted.
  - k>=1: FSM IDLE->SHIFT on accept. op_ready=0 from the next cycle. Latched opcode and remaining=k.
  - Each SHIFT cycle moves data by one bit and decrements remaining.
  - When remaining reaches 1, the final bit moves, FSM->IDLE, and done=1 in the following cycle. op_ready=1 again in that same cycle.
  - Total latency from accept edge to done is k cycles; data_out is visible after every intermediate step.
- Counter:
  - op_count increments by 1 on every completion except NOP.
  - It saturates at 2^CNT_WIDTH-1 (no wrap).
  - count_sat is set on the cycle op_count becomes all-ones and stays set until reset or cnt_clr.
- cnt_clr:
  - Zeros op_count and count_sat next edge.
  - If it coincides with a completion, the clear wins and that operation is not counted.
  - It does not affect data_out or the FSM.
- DOUBLE with DOUBLE_SAT=1:
  - MSB=1 gives all-ones; otherwise data<<1.
  - Unsigned semantics; no overflow output.
- Opcode and shamt are captured at accept; changes while busy have no effect.

Decomposition:
- Package shift_unit_pkg:
  - opcode enum/localparams OP_NOP..OP_DOUBLE.
  - FSM state typedef (ST_IDLE, ST_SHIFT).
  - Function one_step(op, data) returning the single-bit shift/rotate result.
- One natural sub-module: sat_counter (CNT_WIDTH, inc, clr, count, sat), reusable elsewhere.
- The shift FSM and data register stay in the top.

Test Plan:
- Reset mid-shift: WIDTH=8, LOAD 8'hA5, SHL shamt=5, deassert rst_n after 2 SHIFT cycles -> data_out=0, op_ready=1, op_count=0, no done.
- SHL then ASR: LOAD 8'h81, SHL k=3 -> intermediate 8'h02, 8'h04, final 8'h08; done exactly 3 cycles after accept; ASR k=2 on 8'h80 -> 8'hE0; op_count=3.
- ROL wrap-around: LOAD 8'h96, ROL k=7 -> 8'h4B; op_valid pulsed while busy is ignored (op_count unaffected, opcode unchanged).
- DOUBLE both ways: LOAD 8'hC3, DOUBLE -> 8'h86 with DOUBLE_SAT=0 and 8'hFF with DOUBLE_SAT=1; back-to-back single-cycle ops accepted on consecutive cycles.
- Counter saturation: CNT_WIDTH=3, issue 9 LOADs -> op_count=7, count_sat=1 after the 7th; NOPs do not count.
- Counter clear collision: cnt_clr asserted on the completion cycle -> op_count=0; next LOAD -> 1.

Source files
------------

// File: rtl/shift_unit_pkg.sv
// Shared opcodes, FSM state encoding and the single-bit shift helper for shift_unit_param.
// The helper works on a MAX_W-bit word, so the data register may be at most 64 bits wide.
package shift_unit_pkg;

    localparam logic [2:0] OP_NOP    = 3'b000;
    localparam logic [2:0] OP_CLEAR  = 3'b001;
    localparam logic [2:0] OP_LOAD   = 3'b010;
    localparam logic [2:0] OP_SHL    = 3'b011;
    localparam logic [2:0] OP_SHR    = 3'b100;
    localparam logic [2:0] OP_ASR    = 3'b101;
    localparam logic [2:0] OP_ROL    = 3'b110;
    localparam logic [2:0] OP_DOUBLE = 3'b111;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_SHIFT = 1'b1;

    localparam int unsigned MAX_W = 64;
    typedef logic [MAX_W-1:0] word_t;

    // data holds a width-bit value zero-extended to MAX_W; the result is masked back to width.
    function automatic word_t one_step(input logic [2:0] op, input word_t data,
                                       input int unsigned width);
        word_t mask;
        word_t top;
        word_t res;
        logic  msb;
        mask = {MAX_W{1'b1}} >> (MAX_W - width);
        top  = word_t'(1) << (width - 1);
        msb  = |(data & top);
        case (op)
            OP_SHL:  res = data << 1;
            OP_SHR:  res = data >> 1;
            OP_ASR:  res = (data >> 1) | (msb ? top : '0);
            OP_ROL:  res = (data << 1) | word_t'(msb);
            default: res = data;
        endcase
        return res & mask;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky saturation flag; clear takes priority over increment.
module sat_counter #(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 sat
);

    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 sat_q, sat_d;

    always_comb begin
        count_d = count_q;
        sat_d   = sat_q;
        if (clr) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_WIDTH'(1);
            sat_d   = sat_q | (count_d == '1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;
    assign sat   = sat_q;

endmodule

// File: rtl/shift_unit_param.sv
// WIDTH-bit data register with eight opcodes; multi-bit shifts/rotates run one bit per cycle
// behind a valid/ready handshake, and completed operations feed a saturating counter.
module shift_unit_param
    import shift_unit_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned CNT_WIDTH  = 8,
    parameter bit          DOUBLE_SAT = 1'b0,
    parameter int unsigned SH_W       = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [2:0]           control,
    input  logic [WIDTH-1:0]     data_in,
    input  logic [SH_W-1:0]      shamt,
    input  logic                 cnt_clr,
    output logic [WIDTH-1:0]     data_out,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] op_count,
    output logic                 count_sat
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [2:0]       op_q, op_d;
    logic [SH_W-1:0]  rem_q, rem_d;
    logic             done_q, done_d;

    logic             accept;
    logic             serial;
    logic             fin;
    logic [2:0]       fin_op;
    logic             count_inc;
    logic [WIDTH-1:0] dbl;

    assign op_ready = (state_q == ST_IDLE);
    assign accept   = op_valid && op_ready;
    assign serial   = (control == OP_SHL) || (control == OP_SHR) ||
                      (control == OP_ASR) || (control == OP_ROL);
    assign dbl      = (DOUBLE_SAT && data_q[WIDTH-1]) ? '1 : {data_q[WIDTH-2:0], 1'b0};

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        op_d    = op_q;
        rem_d   = rem_q;
        fin     = 1'b0;
        fin_op  = control;
        if (state_q == ST_IDLE) begin
            if (accept) begin
                case (control)
                    OP_CLEAR:  data_d = '0;
                    OP_LOAD:   data_d = data_in;
                    OP_DOUBLE: data_d = dbl;
                    default:   data_d = data_q;
                endcase
                // A zero-length shift completes like a single-cycle op.
                if (serial && (shamt != '0)) begin
                    state_d = ST_SHIFT;
                    op_d    = control;
                    rem_d   = shamt;
                end else begin
                    fin = 1'b1;
                end
            end
        end else begin
            data_d = WIDTH'(one_step(op_q, word_t'(data_q), WIDTH));
            rem_d  = rem_q - SH_W'(1);
            if (rem_q == SH_W'(1)) begin
                state_d = ST_IDLE;
                fin     = 1'b1;
                fin_op  = op_q;
            end
        end
        done_d    = fin;
        count_inc = fin && (fin_op != OP_NOP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            op_q    <= OP_NOP;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            op_q    <= op_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_sat_counter (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (count_inc),
        .clr  (cnt_clr),
        .count(op_count),
        .sat  (count_sat)
    );

    assign data_out = data_q;
    assign done     = done_q;

endmodule

// File: tb/tb_shift_unit_param.sv
// Directed bench for shift_unit_param: dut_a wraps DOUBLE with an 8-bit counter, dut_b
// saturates DOUBLE with a 3-bit counter; both share every input.
module tb_shift_unit_param;
    import shift_unit_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       op_valid;
    logic [2:0] control;
    logic [7:0] data_in;
    logic [2:0] shamt;
    logic       cnt_clr;

    logic       ready_a, done_a, sat_a;
    logic [7:0] data_a, count_a;
    logic       ready_b, done_b, sat_b;
    logic [7:0] data_b;
    logic [2:0] count_b;

    int checks = 0;
    int errors = 0;

    shift_unit_param #(
        .WIDTH     (8),
        .CNT_WIDTH (8),
        .DOUBLE_SAT(1'b0)
    ) dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op_ready (ready_a),
        .control  (control),
        .data_in  (data_in),
        .shamt    (shamt),
        .cnt_clr  (cnt_clr),
        .data_out (data_a),
        .done     (done_a),
        .op_count (count_a),
        .count_sat(sat_a)
    );

    shift_unit_param #(
        .WIDTH     (8),
        .CNT_WIDTH (3),
        .DOUBLE_SAT(1'b1)
    ) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .op_valid (op_valid),
        .op_ready (ready_b),
        .control  (control),
        .data_in  (data_in),
        .shamt    (shamt),
        .cnt_clr  (cnt_clr),
        .data_out (data_b),
        .done     (done_b),
        .op_count (count_b),
        .count_sat(sat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ctl;
        logic [7:0] din;
        logic [2:0] k;
        logic [7:0] exp_a;
        logic [7:0] exp_b;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_cnt();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
    endtask

    // Issues one request and waits for done; lat counts edges after the accept edge.
    task automatic run_op(input logic [2:0] ctl, input logic [7:0] din, input logic [2:0] k,
                          output int lat);
        control  = ctl;
        data_in  = din;
        shamt    = k;
        op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        lat      = 0;
        while (!done_a && lat < 40) begin
            step();
            lat++;
        end
        if (!done_a) begin
            checks++;
            errors++;
            $display("FAIL run_op timeout: done never rose for op %0d", ctl);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int exp_lat;
        int cnt_a;
        int cnt_b;
        logic serial;

        vecs[0]  = '{OP_LOAD,   8'hA5, 3'd0, 8'hA5, 8'hA5};
        vecs[1]  = '{OP_SHL,    8'h5A, 3'd0, 8'hA5, 8'hA5};
        vecs[2]  = '{OP_LOAD,   8'h81, 3'd0, 8'h81, 8'h81};
        vecs[3]  = '{OP_SHL,    8'h5A, 3'd3, 8'h08, 8'h08};
        vecs[4]  = '{OP_SHL,    8'h5A, 3'd4, 8'h80, 8'h80};
        vecs[5]  = '{OP_ASR,    8'h5A, 3'd2, 8'hE0, 8'hE0};
        vecs[6]  = '{OP_SHR,    8'h5A, 3'd3, 8'h1C, 8'h1C};
        vecs[7]  = '{OP_NOP,    8'h5A, 3'd5, 8'h1C, 8'h1C};
        vecs[8]  = '{OP_CLEAR,  8'h5A, 3'd2, 8'h00, 8'h00};
        vecs[9]  = '{OP_LOAD,   8'h96, 3'd0, 8'h96, 8'h96};
        vecs[10] = '{OP_ROL,    8'h5A, 3'd7, 8'h4B, 8'h4B};
        vecs[11] = '{OP_LOAD,   8'hC3, 3'd0, 8'hC3, 8'hC3};
        vecs[12] = '{OP_DOUBLE, 8'h5A, 3'd0, 8'h86, 8'hFF};
        vecs[13] = '{OP_DOUBLE, 8'h5A, 3'd0, 8'h0C, 8'hFF};
        vecs[14] = '{OP_LOAD,   8'h40, 3'd0, 8'h40, 8'h40};
        vecs[15] = '{OP_DOUBLE, 8'h5A, 3'd0, 8'h80, 8'h80};
        vecs[16] = '{OP_ASR,    8'h5A, 3'd7, 8'hFF, 8'hFF};
        vecs[17] = '{OP_ROL,    8'h5A, 3'd1, 8'hFF, 8'hFF};
        vecs[18] = '{OP_LOAD,   8'h01, 3'd0, 8'h01, 8'h01};
        vecs[19] = '{OP_SHR,    8'h5A, 3'd1, 8'h00, 8'h00};

        rst_n    = 1'b0;
        op_valid = 1'b0;
        control  = OP_NOP;
        data_in  = 8'h00;
        shamt    = 3'd0;
        cnt_clr  = 1'b0;
        repeat (3) step();
        chk("reset data_a", data_a, 8'h00);
        chk("reset ready_a", ready_a, 1'b1);
        chk("reset done_a", done_a, 1'b0);
        chk("reset count_a", count_a, 8'h00);
        chk("reset sat_b", sat_b, 1'b0);
        rst_n = 1'b1;
        step();

        // Table-driven pass over every opcode.
        cnt_a = 0;
        cnt_b = 0;
        for (int i = 0; i < 20; i++) begin
            run_op(vecs[i].ctl, vecs[i].din, vecs[i].k, lat);
            serial  = (vecs[i].ctl inside {OP_SHL, OP_SHR, OP_ASR, OP_ROL});
            exp_lat = (serial && vecs[i].k != 3'd0) ? int'(vecs[i].k) : 0;
            if (vecs[i].ctl != OP_NOP) begin
                if (cnt_a < 255) cnt_a++;
                if (cnt_b < 7) cnt_b++;
            end
            chk($sformatf("vec%0d data_a", i), data_a, vecs[i].exp_a);
            chk($sformatf("vec%0d data_b", i), data_b, vecs[i].exp_b);
            chk($sformatf("vec%0d latency", i), lat, exp_lat);
            chk($sformatf("vec%0d done_b", i), done_b, 1'b1);
            chk($sformatf("vec%0d count_a", i), count_a, cnt_a);
            chk($sformatf("vec%0d count_b", i), count_b, cnt_b);
            chk($sformatf("vec%0d sat_b", i), sat_b, cnt_b == 7);
        end
        chk("table sat_a", sat_a, 1'b0);

        // SHL intermediates; a request during the shift must be ignored.
        clr_cnt();
        chk("clr count_a", count_a, 8'h00);
        chk("clr sat_b", sat_b, 1'b0);
        run_op(OP_LOAD, 8'h81, 3'd0, lat);
        control  = OP_SHL;
        shamt    = 3'd3;
        op_valid = 1'b1;
        step();
        chk("shl accept ready", ready_a, 1'b0);
        chk("shl accept data", data_a, 8'h81);
        control  = OP_LOAD;
        data_in  = 8'hFF;
        shamt    = 3'd1;
        step();
        chk("shl step1 data", data_a, 8'h02);
        chk("shl step1 done", done_a, 1'b0);
        op_valid = 1'b0;
        control  = OP_ROL;
        step();
        chk("shl step2 data", data_a, 8'h04);
        chk("shl step2 done", done_a, 1'b0);
        step();
        chk("shl final data", data_a, 8'h08);
        chk("shl final done", done_a, 1'b1);
        chk("shl final ready", ready_a, 1'b1);
        step();
        chk("shl after done", done_a, 1'b0);
        chk("shl after data", data_a, 8'h08);
        chk("shl count", count_a, 8'd2);

        // Back-to-back single-cycle ops.
        op_valid = 1'b1;
        control  = OP_LOAD;
        data_in  = 8'h11;
        step();
        chk("b2b load1 data", data_a, 8'h11);
        chk("b2b load1 done", done_a, 1'b1);
        chk("b2b load1 ready", ready_a, 1'b1);
        data_in = 8'h22;
        step();
        chk("b2b load2 data", data_a, 8'h22);
        control = OP_DOUBLE;
        step();
        chk("b2b double a", data_a, 8'h44);
        chk("b2b double b", data_b, 8'h44);
        chk("b2b double done", done_a, 1'b1);
        op_valid = 1'b0;
        step();
        chk("b2b idle done", done_a, 1'b0);
        chk("b2b count", count_a, 8'd5);

        // Clear coinciding with a single-cycle and with a serial completion.
        cnt_clr  = 1'b1;
        op_valid = 1'b1;
        control  = OP_LOAD;
        data_in  = 8'h33;
        step();
        cnt_clr  = 1'b0;
        op_valid = 1'b0;
        chk("collide count", count_a, 8'd0);
        chk("collide data", data_a, 8'h33);
        chk("collide done", done_a, 1'b1);
        run_op(OP_LOAD, 8'h44, 3'd0, lat);
        chk("post-collide count", count_a, 8'd1);
        control  = OP_SHL;
        shamt    = 3'd2;
        op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        step();
        chk("serial collide mid", data_a, 8'h88);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        chk("serial collide done", done_a, 1'b1);
        chk("serial collide data", data_a, 8'h10);
        chk("serial collide count", count_a, 8'd0);
        run_op(OP_LOAD, 8'h55, 3'd0, lat);
        chk("serial post count", count_a, 8'd1);

        // NOPs do not count; the 3-bit counter saturates at 7.
        clr_cnt();
        for (int i = 0; i < 3; i++) run_op(OP_NOP, 8'h00, 3'd0, lat);
        chk("nop count_a", count_a, 8'd0);
        chk("nop count_b", count_b, 3'd0);
        for (int i = 1; i <= 9; i++) begin
            run_op(OP_LOAD, 8'(i), 3'd0, lat);
            chk($sformatf("sat load%0d count_b", i), count_b, (i < 7) ? i : 7);
            chk($sformatf("sat load%0d sat_b", i), sat_b, i >= 7);
        end
        chk("sat count_a", count_a, 8'd9);

        // Reset in the middle of a shift abandons it without a done pulse.
        run_op(OP_LOAD, 8'hA5, 3'd0, lat);
        control  = OP_SHL;
        shamt    = 3'd5;
        op_valid = 1'b1;
        step();
        op_valid = 1'b0;
        step();
        step();
        chk("pre-reset data", data_a, 8'h94);
        rst_n = 1'b0;
        #1;
        chk("mid reset data", data_a, 8'h00);
        chk("mid reset ready", ready_a, 1'b1);
        chk("mid reset count_a", count_a, 8'd0);
        chk("mid reset sat_b", sat_b, 1'b0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("post reset done%0d", i), done_a, 1'b0);
        end
        chk("post reset data", data_a, 8'h00);
        chk("post reset count", count_a, 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
